// File: rtl/pll_drp_seq.sv
// PLL dynamic-reconfiguration sequencer: walks one ROM configuration, applying each entry as a
// DRP read-modify-write while the PLL is held in reset, then releases reset and waits for lock.
module pll_drp_seq #(
    parameter int N_REGS   = 8,
    parameter int CFG_W    = 2,
    parameter int DRP_TMO  = 64,
    parameter int LOCK_TMO = 65536,
    localparam int IDX_W   = $clog2(N_REGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req,
    input  logic [CFG_W-1:0]       cfg_sel,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [CFG_W+IDX_W-1:0] rom_addr,
    input  logic [38:0]            rom_data,
    output logic [6:0]             drp_addr,
    output logic [15:0]            drp_di,
    input  logic [15:0]            drp_do,
    output logic                   drp_den,
    output logic                   drp_dwe,
    input  logic                   drp_drdy,
    output logic                   pll_rst,
    input  logic                   pll_locked
);
    localparam int TMO_MAX     = (DRP_TMO > LOCK_TMO) ? DRP_TMO : LOCK_TMO;
    localparam int CNT_W       = $clog2(TMO_MAX + 1);
    localparam int LOCK_IGNORE = 4;

    typedef enum logic [2:0] {
        IDLE, ROM_RD, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, LOCK_WAIT
    } state_t;

    state_t             state_reg, state_next;
    logic [CFG_W-1:0]   cfg_reg, cfg_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               rom_phase_reg, rom_phase_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [6:0]         addr_reg, addr_next;
    logic [15:0]        keep_reg, keep_next;
    logic [15:0]        data_reg, data_next;
    logic [15:0]        di_reg, di_next;
    logic               den_reg, den_next;
    logic               dwe_reg, dwe_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;
    logic               pll_rst_reg, pll_rst_next;
    logic               lock_meta_reg, lock_sync_reg;
    logic [15:0]        merged_di;
    logic               drp_expired, lock_expired;

    // Bits selected by keep_mask survive from the read-back; data supplies the rest.
    for (genvar gi = 0; gi < 16; gi++) begin : g_merge
        assign merged_di[gi] = (drp_do[gi] & keep_reg[gi]) | data_reg[gi];
    end

    // cnt_reg counts cycles since the last den pulse, or since PLL reset release.
    assign drp_expired  = (cnt_reg == CNT_W'(DRP_TMO - 1));
    assign lock_expired = (cnt_reg == CNT_W'(LOCK_TMO - 1));

    always_comb begin
        state_next     = state_reg;
        cfg_next       = cfg_reg;
        idx_next       = idx_reg;
        rom_phase_next = rom_phase_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        keep_next      = keep_reg;
        data_next      = data_reg;
        di_next        = di_reg;
        den_next       = 1'b0;
        dwe_next       = 1'b0;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        err_next       = err_reg;
        pll_rst_next   = pll_rst_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    cfg_next       = cfg_sel;
                    idx_next       = '0;
                    rom_phase_next = 1'b0;
                    err_next       = 1'b0;
                    busy_next      = 1'b1;
                    pll_rst_next   = 1'b1;
                    state_next     = ROM_RD;
                end
            end
            ROM_RD: begin
                if (!rom_phase_reg) begin
                    rom_phase_next = 1'b1;
                end else begin
                    rom_phase_next = 1'b0;
                    addr_next      = rom_data[38:32];
                    keep_next      = rom_data[31:16];
                    data_next      = rom_data[15:0];
                    den_next       = 1'b1;
                    state_next     = RD_REQ;
                end
            end
            RD_REQ: begin
                cnt_next   = CNT_W'(1);
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (drp_drdy) begin
                    di_next    = merged_di;
                    den_next   = 1'b1;
                    dwe_next   = 1'b1;
                    state_next = WR_REQ;
                end else if (drp_expired) begin
                    err_next     = 1'b1;
                    pll_rst_next = 1'b0;
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WR_REQ: begin
                cnt_next   = CNT_W'(1);
                state_next = WR_WAIT;
            end
            WR_WAIT: begin
                if (drp_drdy) begin
                    if (idx_reg == IDX_W'(N_REGS - 1)) begin
                        pll_rst_next = 1'b0;
                        cnt_next     = '0;
                        state_next   = LOCK_WAIT;
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = ROM_RD;
                    end
                end else if (drp_expired) begin
                    err_next     = 1'b1;
                    pll_rst_next = 1'b0;
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            LOCK_WAIT: begin
                // Lock seen in the first cycles after release may be left over from before reset.
                if (cnt_reg >= CNT_W'(LOCK_IGNORE) && lock_sync_reg) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else if (lock_expired) begin
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cfg_reg       <= '0;
            idx_reg       <= '0;
            rom_phase_reg <= 1'b0;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            keep_reg      <= '0;
            data_reg      <= '0;
            di_reg        <= '0;
            den_reg       <= 1'b0;
            dwe_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            pll_rst_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cfg_reg       <= cfg_next;
            idx_reg       <= idx_next;
            rom_phase_reg <= rom_phase_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            keep_reg      <= keep_next;
            data_reg      <= data_next;
            di_reg        <= di_next;
            den_reg       <= den_next;
            dwe_reg       <= dwe_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            pll_rst_reg   <= pll_rst_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_reg <= 1'b0;
            lock_sync_reg <= 1'b0;
        end else begin
            lock_meta_reg <= pll_locked;
            lock_sync_reg <= lock_meta_reg;
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err      = err_reg;
    assign rom_addr = {cfg_reg, idx_reg};
    assign drp_addr = addr_reg;
    assign drp_di   = di_reg;
    assign drp_den  = den_reg;
    assign drp_dwe  = dwe_reg;
    assign pll_rst  = pll_rst_reg;

endmodule

// File: tb/tb_pll_drp_seq.sv
// Directed bench for pll_drp_seq: ROM, DRP slave and PLL lock models driven on the falling edge,
// with a transaction-level expectation list checked against the DUT every cycle.
module tb_pll_drp_seq;
    localparam int N_REGS   = 8;
    localparam int CFG_W    = 2;
    localparam int IDX_W    = 3;
    localparam int DRP_TMO  = 64;
    localparam int LOCK_TMO = 300;
    localparam int DRP_LAT  = 3;

    logic                   clk;
    logic                   rst_n;
    logic                   req;
    logic [CFG_W-1:0]       cfg_sel;
    logic                   busy, done, err;
    logic [CFG_W+IDX_W-1:0] rom_addr;
    logic [38:0]            rom_data;
    logic [6:0]             drp_addr;
    logic [15:0]            drp_di, drp_do;
    logic                   drp_den, drp_dwe, drp_drdy;
    logic                   pll_rst, pll_locked;

    pll_drp_seq #(.N_REGS(N_REGS), .CFG_W(CFG_W), .DRP_TMO(DRP_TMO), .LOCK_TMO(LOCK_TMO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .cfg_sel(cfg_sel),
        .busy(busy), .done(done), .err(err),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .drp_addr(drp_addr), .drp_di(drp_di), .drp_do(drp_do),
        .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_drdy(drp_drdy),
        .pll_rst(pll_rst), .pll_locked(pll_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
        int          idx;
    } txn_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [38:0] rom [4*N_REGS];
    txn_t        exp_a [2*N_REGS];
    int          exp_n, rd_ptr, cyc;
    int          cur_cfg, chk_mode, lock_delay, withhold_at;
    bit          glitch, mem_ffff, pin_di, exp_err, done_seen;
    logic        prev_den, prev_busy, prev_done, prev_pll_rst;
    int          last_den_cyc, fall_cyc, done_cyc;
    logic [15:0] drp_mem [128];
    int          pend_cnt, acc_no;
    logic        pend_we;
    logic [6:0]  pend_addr;
    logic [15:0] pend_di;
    logic [CFG_W+IDX_W-1:0] rom_prev;
    bit          releasing, lock_prev_rst;
    int          since;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [15:0] mem_val(input int a);
        return mem_ffff ? 16'hFFFF : (16'h5A5A ^ 16'(a * 515));
    endfunction

    // Expected DRP traffic: read then merged write per entry, tracking repeated addresses.
    task automatic build_expect(input int cfg, input int limit);
        logic [15:0] shadow [128];
        logic [38:0] ent;
        int n;
        for (int a = 0; a < 128; a++) shadow[a] = mem_val(a);
        n = 0;
        for (int i = 0; i < N_REGS; i++) begin
            ent = rom[cfg*N_REGS + i];
            exp_a[n].we = 1'b0; exp_a[n].addr = ent[38:32]; exp_a[n].di = '0; exp_a[n].idx = i;
            n++;
            shadow[ent[38:32]] = (shadow[ent[38:32]] & ent[31:16]) | ent[15:0];
            exp_a[n].we = 1'b1; exp_a[n].addr = ent[38:32]; exp_a[n].di = shadow[ent[38:32]];
            exp_a[n].idx = i;
            n++;
        end
        exp_n = (limit < n) ? limit : n;
    endtask

    task automatic check_cycle();
        logic [CFG_W+IDX_W-1:0] ra;
        if (!rst_n) begin
            prev_den = 0; prev_busy = 0; prev_done = 0; prev_pll_rst = 0;
            return;
        end
        if (busy && !prev_busy) rd_ptr = 0;
        if (drp_den) begin
            chk_eq("den_back_to_back", prev_den, 1'b0);
            if (rd_ptr >= exp_n) begin
                n_tests++; n_fail++;
                $display("FAIL den_unexpected: got access %0d, required at most %0d (cycle %0d)",
                         rd_ptr + 1, exp_n, cyc);
            end else begin
                ra = {CFG_W'(cur_cfg), IDX_W'(exp_a[rd_ptr].idx)};
                chk_eq("drp_we", drp_dwe, exp_a[rd_ptr].we);
                chk_eq("drp_addr", drp_addr, exp_a[rd_ptr].addr);
                chk_eq("rom_addr", rom_addr, ra);
                if (exp_a[rd_ptr].we) begin
                    chk_eq("drp_di", drp_di, exp_a[rd_ptr].di);
                    if (pin_di) chk_eq("drp_di_literal", drp_di, 16'h1145);
                end
                rd_ptr++;
            end
            last_den_cyc = cyc;
        end else if (drp_dwe) begin
            chk_eq("dwe_without_den", drp_dwe, 1'b0);
        end
        if (!busy) chk_eq("pll_rst_idle", pll_rst, 1'b0);
        else if (rd_ptr < exp_n) chk_eq("pll_rst_held", pll_rst, 1'b1);
        if (prev_pll_rst && !pll_rst) fall_cyc = cyc;
        if (done) begin
            done_seen = 1; done_cyc = cyc;
            chk_eq("done_with_busy_fall", {prev_busy, busy}, 2'b10);
            chk_eq("done_single_pulse", prev_done, 1'b0);
            chk_eq("done_err", err, exp_err);
            chk_eq("txn_count", rd_ptr, exp_n);
            case (chk_mode)
                0: chk_eq("lock_latency", cyc - fall_cyc, lock_delay + 3);
                1: chk_eq("drp_tmo_latency", cyc - last_den_cyc, DRP_TMO);
                default: chk_eq("lock_tmo_latency", cyc - fall_cyc, LOCK_TMO);
            endcase
        end
        prev_den = drp_den; prev_busy = busy; prev_done = done; prev_pll_rst = pll_rst;
    endtask

    task automatic drive_drp();
        drp_drdy = 1'b0;
        drp_do   = 16'hBAD0;
        if (!rst_n) begin
            pend_cnt = 0;
            return;
        end
        rom_data = rom[rom_prev];
        rom_prev = rom_addr;
        if (!busy) begin
            for (int a = 0; a < 128; a++) drp_mem[a] = mem_val(a);
            acc_no = 0;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                drp_drdy = 1'b1;
                if (pend_we) drp_mem[pend_addr] = pend_di;
                else drp_do = drp_mem[pend_addr];
            end
        end
        if (drp_den) begin
            if (acc_no != withhold_at) begin
                pend_cnt = DRP_LAT; pend_we = drp_dwe; pend_addr = drp_addr; pend_di = drp_di;
            end
            acc_no++;
        end
    endtask

    task automatic drive_lock();
        if (!rst_n || !busy) releasing = 0;
        else if (lock_prev_rst && !pll_rst) begin releasing = 1; since = 0; end
        else if (releasing) since++;
        lock_prev_rst = pll_rst;
        if (releasing) pll_locked = (glitch && since < 2) || (lock_delay >= 0 && since >= lock_delay);
        else pll_locked = glitch;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        check_cycle();
        drive_drp();
        drive_lock();
    endtask

    task automatic check_reset(input string name);
        chk_eq({name, "_ctrl"}, {busy, done, err, pll_rst, drp_den, drp_dwe}, 6'b0);
        chk_eq({name, "_addr"}, {drp_addr, rom_addr}, 0);
        chk_eq({name, "_di"}, drp_di, 0);
    endtask

    task automatic start_seq(input int cfg, input int mode, input int ldelay, input bit gl,
                             input int withhold, input bit ffff, input bit pin, input bit e_err);
        cur_cfg = cfg; chk_mode = mode; lock_delay = ldelay; glitch = gl;
        withhold_at = withhold; mem_ffff = ffff; pin_di = pin; exp_err = e_err; done_seen = 0;
        build_expect(cfg, (mode == 1) ? withhold + 1 : 2*N_REGS);
        tick();
        cfg_sel = CFG_W'(cfg);
        req = 1'b1;
        tick();
        req = 1'b0;
        chk_eq("accept_busy", busy, 1'b1);
        chk_eq("accept_pll_rst", pll_rst, 1'b1);
        chk_eq("accept_err_clear", err, 1'b0);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 2000 && !done_seen; i++) tick();
        chk_eq({name, "_done_seen"}, done_seen, 1'b1);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < N_REGS; i++) begin
            rom[0*N_REGS + i] = {7'(8 + i), 16'h1000, 16'h0145};
            rom[1*N_REGS + i] = {7'(7'h20 + i), 16'h0F0F, 16'h5050};
            rom[2*N_REGS + i] = {7'(7'h40 + 3*i), 16'hFF00, 16'(16'h00A0 + i)};
            rom[3*N_REGS + i] = {7'(7'h10 + i % 2), 16'h00FF, 16'(i << 12)};
        end
        req = 0; cfg_sel = 0; rom_data = '0; drp_do = '0; drp_drdy = 0; pll_locked = 0;
        cyc = 0; rd_ptr = 0; exp_n = 0; cur_cfg = 0; chk_mode = 0; lock_delay = -1;
        withhold_at = -1; glitch = 0; mem_ffff = 1; pin_di = 0; exp_err = 0; done_seen = 0;
        pend_cnt = 0; acc_no = 0; rom_prev = '0; releasing = 0; lock_prev_rst = 0; since = 0;
        last_den_cyc = 0; fall_cyc = 0; done_cyc = 0;
        rst_n = 0;
        repeat (3) tick();
        check_reset("rst_init");
        rst_n = 1;
        repeat (3) tick();

        // Normal run: reads return 0xFFFF, every write must be 0x1145, lock 100 cycles later.
        start_seq(0, 0, 100, 0, -1, 1, 1, 0);
        wait_done("normal");
        chk_eq("lit_lock_latency", done_cyc - fall_cyc, 103);
        repeat (5) tick();

        // Config 2 with an ignored request mid-sequence.
        start_seq(2, 0, 40, 0, -1, 0, 0, 0);
        repeat (20) tick();
        cfg_sel = 2'd1; req = 1'b1;
        tick();
        req = 1'b0; cfg_sel = 2'd2;
        chk_eq("mid_req_busy", busy, 1'b1);
        wait_done("cfg2");
        repeat (5) tick();

        // DRP timeout on the third read.
        start_seq(1, 1, 0, 0, 4, 0, 0, 1);
        wait_done("drp_tmo");
        chk_eq("lit_drp_tmo", done_cyc - last_den_cyc, 64);
        repeat (20) tick();
        chk_eq("err_sticky", err, 1'b1);

        // Lock timeout, then a clean run that must clear err on acceptance.
        start_seq(3, 2, -1, 0, -1, 0, 0, 1);
        wait_done("lock_tmo");
        repeat (5) tick();
        start_seq(0, 0, 10, 0, -1, 0, 0, 0);
        wait_done("after_tmo");
        repeat (5) tick();

        // Stale lock still present just after release must be ignored.
        start_seq(3, 0, 60, 1, -1, 0, 0, 0);
        wait_done("glitch");
        chk_eq("lit_glitch_latency", done_cyc - fall_cyc, 63);
        repeat (5) tick();

        // Reset while a write is outstanding, then a full run.
        start_seq(2, 0, 40, 0, -1, 0, 0, 0);
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            tick();
            if (drp_den && drp_dwe) seen = 1;
        end
        chk_eq("write_reached", seen, 1'b1);
        tick();
        #2 rst_n = 0;
        #1 check_reset("rst_mid_write");
        tick();
        tick();
        rst_n = 1;
        repeat (3) tick();
        start_seq(2, 0, 40, 0, -1, 0, 0, 0);
        wait_done("after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_drp_seq.md
# pll_drp_seq

Dynamic-reconfiguration sequencer for the board PLL on the Xilinx target. On request it walks a ROM table of register updates for one selected configuration, applies each update as a read-modify-write over the PLL DRP port while holding the PLL in reset, then releases reset and waits for lock. It sits beside the top clock generator and lets the core retune derived clocks, such as the audio clock, without a new bitstream.

## Interface
Parameters:
- N_REGS, 8: DRP entries per configuration (power of 2, ≥2); IDX_W = log2(N_REGS).
- CFG_W, 2: configuration select width (up to 4 configs).
- DRP_TMO, 64: max cycles waiting for drp_drdy per access.
- LOCK_TMO, 65536: max cycles waiting for lock after PLL reset release.

Ports:
- clk  in  1  single clock, also drives the DRP port.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  start pulse; sampled only in IDLE.
- cfg_sel  in  CFG_W  configuration index; latched with req.
- busy  out  1  high from accepted req until done.
- done  out  1  one-cycle pulse at end of sequence, success or failure.
- err  out  1  sticky failure flag; cleared by next accepted req.
- rom_addr  out  CFG_W+IDX_W  {cfg, idx}.
- rom_data  in  39  {addr[38:32], keep_mask[31:16], data[15:0]}; valid 1 cycle after rom_addr changes.
- drp_addr  out  7; drp_di  out  16; drp_do  in  16.
- drp_den  out  1; drp_dwe  out  1; drp_drdy  in  1.
- pll_rst  out  1  PLL reset, active high.
- pll_locked  in  1  asynchronous PLL lock.

## Operation
- States: IDLE, ROM_RD, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, LOCK_WAIT.
- IDLE: req=1 → latch cfg_sel, idx=0, err=0, busy=1, pll_rst=1 → ROM_RD.
- ROM_RD: present rom_addr, wait one cycle, register rom_data → RD_REQ.
- RD_REQ: drp_den=1, drp_dwe=0, drp_addr=entry addr, for exactly one cycle → RD_WAIT.
- RD_WAIT: on drp_drdy capture drp_do → WR_REQ.
- WR_REQ: drp_den=1, drp_dwe=1 for one cycle, drp_di = (drp_do_captured & keep_mask) | data → WR_WAIT.
- WR_WAIT: on drp_drdy: if idx==N_REGS-1 → LOCK_WAIT with pll_rst=0; else idx+1 → ROM_RD.
- LOCK_WAIT: pll_locked passes through a 2-FF synchronizer; ignore it for the first 4 cycles after release; then synced lock high → IDLE, done=1, busy=0.
- DRP timeout: a wait counter restarts at each den pulse; DRP_TMO cycles in RD_WAIT/WR_WAIT without drdy → err=1, pll_rst=0, done=1 → IDLE. Remaining entries are skipped.
- Lock timeout: LOCK_TMO cycles in LOCK_WAIT → err=1, done=1 → IDLE.
- drdy outside RD_WAIT/WR_WAIT is ignored. req while busy is ignored; no queuing.

## Timing
- Reset (rst_n=0, any time, including mid-sequence): state=IDLE, busy=0, done=0, err=0, pll_rst=0, drp_den=0, drp_dwe=0, drp_addr=0, drp_di=0, rom_addr=0. Outputs reach these values asynchronously. An interrupted DRP access is abandoned.
- req on cycle T → busy and pll_rst high at T+1.
- Per entry: 2 (ROM) + 1 (read den) + read latency + 1 (write den) + write latency cycles.
- drp_den is never high for two consecutive cycles. drp_dwe is high only together with drp_den.
- done is a single-cycle pulse, coincident with busy falling; err is valid in that cycle and holds afterwards.
- pll_rst falls on the cycle after the last write's drdy, and stays high continuously from acceptance until then.
- If drdy arrives on the same cycle the timeout expires, drdy takes precedence.

## Test plan
- Normal: N_REGS=8; DRP model with 3-cycle drdy, reads return 0xFFFF; entry keep_mask=0x1000, data=0x0145 → drp_di=0x1145. Check all 8 addresses are written in order. pll_rst is high throughout, then falls. Lock asserted 100 cycles later → done pulse, err=0.
- cfg_sel=2 → rom_addr runs from {2,0} to {2,7}; a req pulsed mid-sequence with cfg_sel=1 changes nothing.
- DRP timeout: withhold drdy on the 3rd read → done pulse at exactly DRP_TMO cycles after its den, err=1, pll_rst=0, no further den.
- Lock timeout: keep pll_locked=0 → done with err=1 after LOCK_TMO cycles. The next req clears err.
- Lock glitch: pll_locked is still high in the first 2 cycles after release → ignored; done waits for the real lock.
- Reset mid-write: drop rst_n during WR_WAIT → all outputs take their reset values immediately. After release, a new req runs a full sequence.
